uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 208 ++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampled UART receiver feeding a small receive FIFO.
// Each frame is majority-sampled mid-bit and stored with its parity/framing flags.
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        mclkx16,
  input  logic                        reset,
  input  logic                        rx,
  input  logic                        read,
  output logic [DATA_BITS-1:0]        rdata,
  output logic                        rxrdy,
  output logic                        parityerr,
  output logic                        framingerr,
  output logic                        overrun,
  output logic                        break_det,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [2:0]                  dbg_state_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           tick_q, tick_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bit_q, par_bit_d;
  logic [1:0]           samp_q, samp_d;
  logic                 rx_meta_q, rx_sync_q, rx_prev_q;
  logic [1:0]           arm_q;
  logic                 hold_q, hold_d;
  logic                 bit_val, start_edge, push;
  logic                 data_xor, frame_pe, frame_fe, frame_brk;

  // hold_q blocks start detection until the synchronized line has really been
  // seen high: after reset (sync flops preset to 1) and after a break.
  always_ff @(posedge mclkx16 or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      arm_q     <= 2'b00;
      hold_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      arm_q     <= {arm_q[0], 1'b1};
      hold_q    <= hold_d;
    end
  end

  always_comb begin
    hold_d = hold_q;
    if (arm_q[1] && rx_sync_q) hold_d = 1'b0;
    if (push && frame_brk)     hold_d = 1'b1;
  end

  assign start_edge = rx_prev_q & ~rx_sync_q & ~hold_q;
  assign bit_val    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_sync_q) |
                      (samp_q[1] & rx_sync_q);

  assign data_xor  = ^shift_q;
  assign frame_fe  = ~bit_val;
  assign frame_brk = (shift_q == '0) && ((PARITY == 0) || !par_bit_q) && !bit_val;

  always_comb begin
    frame_pe = 1'b0;
    if (PARITY == 1)      frame_pe = ~(data_xor ^ par_bit_q);
    else if (PARITY == 2) frame_pe = data_xor ^ par_bit_q;
  end

  always_ff @(posedge mclkx16 or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      tick_q    <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_bit_q <= 1'b0;
      samp_q    <= '0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_bit_q <= par_bit_d;
      samp_q    <= samp_d;
    end
  end

  // Decisions are taken at tick 9 from samples at ticks 7, 8 and the live tick-9 value.
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_bit_d = par_bit_q;
    samp_d    = samp_q;
    push      = 1'b0;
    if (state_q != ST_IDLE) begin
      tick_d = tick_q + 4'd1;
      if (tick_q == 4'd7) samp_d[0] = rx_sync_q;
      if (tick_q == 4'd8) samp_d[1] = rx_sync_q;
    end
    unique case (state_q)
      ST_IDLE: begin
        tick_d = '0;
        if (start_edge) state_d = ST_START;
      end
      ST_START: begin
        if (tick_q == 4'd9 && bit_val) begin
          state_d = ST_IDLE;
          tick_d  = '0;
        end else if (tick_q == 4'd15) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (tick_q == 4'd9) shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
        if (tick_q == 4'd15) begin
          if (bit_cnt_q == LAST_BIT) state_d = (PARITY == 0) ? ST_STOP : ST_PARITY;
          else                       bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      ST_PARITY: begin
        if (tick_q == 4'd9)  par_bit_d = bit_val;
        if (tick_q == 4'd15) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (tick_q == 4'd9) begin
          push    = 1'b1;
          state_d = ST_IDLE;
          tick_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign dbg_state_o = state_q;

  // Pop handshake: rxrdy acts as valid and read as ready; an entry leaves the
  // FIFO on an mclkx16 edge where both are high. read while empty is ignored.
  logic [DATA_BITS+1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q, count_d;
  logic                 overrun_q, overrun_d, brk_q, brk_d;
  logic                 empty, full, pop, push_ok, ovr_set;
  logic [DATA_BITS+1:0] head;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_C);
  assign pop     = read & ~empty;
  assign push_ok = push & (~full | pop);
  assign ovr_set = push & full & ~pop;

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push_ok) count_d = count_q - 1'b1;
  end

  // Set wins over the pop-clear when both happen in one cycle.
  assign overrun_d = ovr_set | (overrun_q & ~pop);
  assign brk_d     = (push & frame_brk) | (brk_q & ~pop);

  always_ff @(posedge mclkx16 or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      brk_q     <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      brk_q     <= brk_d;
    end
  end

  always_ff @(posedge mclkx16) begin
    if (push_ok) mem_q[wr_ptr_q] <= {frame_pe, frame_fe, shift_q};
  end

  assign head       = mem_q[rd_ptr_q];
  assign rxrdy      = ~empty;
  assign rdata      = empty ? '0 : head[DATA_BITS-1:0];
  assign framingerr = ~empty & head[DATA_BITS];
  assign parityerr  = ~empty & head[DATA_BITS+1];
  assign overrun    = overrun_q;
  assign break_det  = brk_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: 8-bit odd-parity instance (a) and 7-bit no-parity instance (b).
// Frames are bit-banged at 16 clocks per bit; expected entries go through scoreboard queues.
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_a, rx_a, read_a;
  logic [7:0] rdata_a;
  logic       rxrdy_a, pe_a, fe_a, ovr_a, brk_a;
  logic [2:0] count_a, state_a;

  logic       reset_b, rx_b, read_b;
  logic [6:0] rdata_b;
  logic       rxrdy_b, pe_b, fe_b, ovr_b, brk_b;
  logic [2:0] count_b, state_b;

  uart_rx_fifo #(.DATA_BITS(8), .PARITY(1), .FIFO_DEPTH(4)) dut_a (
    .mclkx16(clk), .reset(reset_a), .rx(rx_a), .read(read_a),
    .rdata(rdata_a), .rxrdy(rxrdy_a), .parityerr(pe_a), .framingerr(fe_a),
    .overrun(ovr_a), .break_det(brk_a), .fifo_count(count_a), .dbg_state_o(state_a)
  );

  uart_rx_fifo #(.DATA_BITS(7), .PARITY(0), .FIFO_DEPTH(4)) dut_b (
    .mclkx16(clk), .reset(reset_b), .rx(rx_b), .read(read_b),
    .rdata(rdata_b), .rxrdy(rxrdy_b), .parityerr(pe_b), .framingerr(fe_b),
    .overrun(ovr_b), .break_det(brk_b), .fifo_count(count_b), .dbg_state_o(state_b)
  );

  // Entry layout: {parityerr, framingerr, data[7:0]}
  logic [9:0] exp_q[$];
  logic [9:0] exp_b_q[$];
  logic       exp_ovr;
  int         n_checks = 0;
  int         n_pass   = 0;

  typedef struct {
    logic [7:0] data;
    logic       pbit;
    logic       stop;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [9:0] head_a();
    return {pe_a, fe_a, rdata_a};
  endfunction

  function automatic logic [9:0] head_b();
    return {pe_b, fe_b, 1'b0, rdata_b};
  endfunction

  function automatic logic [15:0] frame_a(input logic [7:0] d, input logic p, input logic s);
    return {5'b11111, s, p, d, 1'b0};
  endfunction

  function automatic logic [15:0] frame_b(input logic [6:0] d, input logic s);
    return {7'b1111111, s, d, 1'b0};
  endfunction

  task automatic expect_frame(input logic [9:0] e);
    if (exp_q.size() < 4) exp_q.push_back(e);
    else exp_ovr = 1'b1;
  endtask

  // Called right after a negedge. After the wait in iteration k the bench sits in
  // cycle k after the start bit was driven; the stop-bit push lands on the edge
  // ending cycle 171 of an 11-bit frame.
  task automatic drive_frame(input bit sel, input logic [15:0] fb, input int nb,
                             input int read_at, input bit chk_lat);
    logic [9:0] e;
    for (int k = 0; k < nb * 16; k++) begin
      if (sel) rx_b = fb[k[7:4]];
      else     rx_a = fb[k[7:4]];
      @(negedge clk);
      if (chk_lat && k == 171) check("latency_rxrdy_before", 32'(rxrdy_a), 32'd0);
      if (chk_lat && k == 172) check("latency_rxrdy_after", 32'(rxrdy_a), 32'd1);
      if (!sel) begin
        if (k == read_at && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          exp_ovr = 1'b0;
          check("simul_pop_head", 32'(head_a()), 32'(e));
        end
        read_a = (k == read_at);
      end
    end
    read_a = 1'b0;
    if (sel) rx_b = 1'b1;
    else     rx_a = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pop_chk(input bit sel, input string name);
    logic [9:0] e;
    if (sel) begin
      if (exp_b_q.size() == 0) begin
        n_checks++;
        $display("FAIL %s: scoreboard empty, got 0x%0h", name, head_b());
      end else begin
        e = exp_b_q.pop_front();
        check(name, 32'(head_b()), 32'(e));
      end
      read_b = 1'b1;
      @(negedge clk);
      read_b = 1'b0;
    end else begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL %s: scoreboard empty, got 0x%0h", name, head_a());
      end else begin
        e = exp_q.pop_front();
        check(name, 32'(head_a()), 32'(e));
      end
      read_a = 1'b1;
      @(negedge clk);
      read_a = 1'b0;
      exp_ovr = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] d;
    reset_a = 1'b1; reset_b = 1'b1;
    rx_a = 1'b1; rx_b = 1'b1;
    read_a = 1'b0; read_b = 1'b0;
    exp_ovr = 1'b0;

    // data, parity bit, stop bit, expected parityerr, expected framingerr (odd parity)
    vecs[0] = '{8'h5A, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h5A, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{8'hFF, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h01, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{8'hA5, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{8'hC3, 1'b1, 1'b1, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    check("reset_outputs_a", 32'({rdata_a, rxrdy_a, pe_a, fe_a, ovr_a, brk_a, count_a}), 32'd0);
    check("reset_state_a", 32'(state_a), 32'd0);
    reset_a = 1'b0;
    reset_b = 1'b0;
    repeat (8) @(negedge clk);

    // 0x5A with correct odd parity; read held at the push cycle on an empty FIFO
    drive_frame(1'b0, frame_a(8'h5A, 1'b1, 1'b1), 11, 171, 1'b1);
    expect_frame({2'b00, 8'h5A});
    check("single_count", 32'(count_a), 32'd1);
    check("single_rxrdy", 32'(rxrdy_a), 32'd1);
    pop_chk(1'b0, "single_head");
    check("single_count_after_pop", 32'(count_a), 32'd0);

    // Table: frames in pairs, both popped in arrival order
    for (int i = 0; i < 8; i++) begin
      drive_frame(1'b0, frame_a(vecs[i].data, vecs[i].pbit, vecs[i].stop), 11, -1, 1'b0);
      expect_frame({vecs[i].exp_pe, vecs[i].exp_fe, vecs[i].data});
      if (i % 2 == 1) begin
        check("table_count", 32'(count_a), 32'd2);
        pop_chk(1'b0, "table_first");
        pop_chk(1'b0, "table_second");
      end
    end

    // Five frames into a 4-deep FIFO with no reads
    for (int i = 1; i <= 5; i++) begin
      d = 8'(i);
      drive_frame(1'b0, frame_a(d, ~^d, 1'b1), 11, -1, 1'b0);
      expect_frame({2'b00, d});
    end
    check("overflow_count", 32'(count_a), 32'd4);
    check("overflow_overrun_set", 32'(ovr_a), 32'(exp_ovr));
    pop_chk(1'b0, "overflow_pop1");
    check("overflow_overrun_cleared", 32'(ovr_a), 32'(exp_ovr));
    for (int i = 0; i < 3; i++) pop_chk(1'b0, "overflow_pop_rest");
    check("overflow_drained", 32'({rxrdy_a, count_a}), 32'd0);
    read_a = 1'b1;
    @(negedge clk);
    read_a = 1'b0;
    check("read_empty_ignored", 32'({rdata_a, count_a}), 32'd0);

    // Push and pop in the same cycle on a full FIFO
    for (int i = 0; i < 4; i++) begin
      d = 8'h11 + 8'(i);
      drive_frame(1'b0, frame_a(d, ~^d, 1'b1), 11, -1, 1'b0);
      expect_frame({2'b00, d});
    end
    check("full_count", 32'(count_a), 32'd4);
    drive_frame(1'b0, frame_a(8'h15, ~^8'h15, 1'b1), 11, 171, 1'b0);
    expect_frame({2'b00, 8'h15});
    check("simul_full_count", 32'(count_a), 32'd4);
    check("simul_full_no_overrun", 32'(ovr_a), 32'(exp_ovr));
    for (int i = 0; i < 4; i++) pop_chk(1'b0, "simul_full_drain");

    // False start: line low for 5 cycles only
    rx_a = 1'b0;
    repeat (5) @(negedge clk);
    rx_a = 1'b1;
    @(negedge clk);
    check("false_start_entered", 32'(state_a), 32'd1);
    repeat (30) @(negedge clk);
    check("false_start_idle", 32'(state_a), 32'd0);
    check("false_start_no_push", 32'({rxrdy_a, count_a}), 32'd0);

    // Break: line low for two frame times; zero data and parity also flag odd parity
    exp_q.push_back({1'b1, 1'b1, 8'h00});
    rx_a = 1'b0;
    repeat (352) @(negedge clk);
    check("break_det_set", 32'(brk_a), 32'd1);
    check("break_one_entry", 32'(count_a), 32'd1);
    check("break_state_idle", 32'(state_a), 32'd0);
    rx_a = 1'b1;
    repeat (40) @(negedge clk);
    check("break_no_second_push", 32'(count_a), 32'd1);
    pop_chk(1'b0, "break_entry");
    check("break_det_cleared", 32'(brk_a), 32'd0);

    // 7-bit, no parity: receive, reset mid-frame, then receive again
    drive_frame(1'b1, frame_b(7'h7F, 1'b1), 9, -1, 1'b0);
    exp_b_q.push_back({2'b00, 8'h7F});
    check("b_count", 32'(count_b), 32'd1);
    check("b_head_7f", 32'(head_b()), 32'(exp_b_q[0]));
    rx_b = 1'b0;
    repeat (16) @(negedge clk);
    rx_b = 1'b1;
    repeat (16) @(negedge clk);
    rx_b = 1'b0;
    repeat (8) @(negedge clk);
    reset_b = 1'b1;
    exp_b_q.delete();
    repeat (3) @(negedge clk);
    check("b_reset_outputs",
          32'({rdata_b, rxrdy_b, pe_b, fe_b, ovr_b, brk_b, count_b, state_b}), 32'd0);
    reset_b = 1'b0;
    repeat (20) @(negedge clk);
    check("b_no_start_while_low", 32'({state_b, count_b}), 32'd0);
    rx_b = 1'b1;
    repeat (20) @(negedge clk);
    check("b_aborted_no_push", 32'(count_b), 32'd0);
    drive_frame(1'b1, frame_b(7'h15, 1'b1), 9, -1, 1'b0);
    exp_b_q.push_back({2'b00, 8'h15});
    check("b_count_after", 32'(count_b), 32'd1);
    pop_chk(1'b1, "b_head_15");
    check("b_empty_after", 32'(count_b), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
